// File: rtl/l2_ctrl_pkg.sv
// Shared encodings for the L2 access front end: trace command codes,
// request source ids and sequencer states.
package l2_ctrl_pkg;

  localparam logic [3:0] CMD_DREAD     = 4'd0;
  localparam logic [3:0] CMD_DWRITE    = 4'd1;
  localparam logic [3:0] CMD_IREAD     = 4'd2;
  localparam logic [3:0] CMD_SNP_INV   = 4'd3;
  localparam logic [3:0] CMD_SNP_RD    = 4'd4;
  localparam logic [3:0] CMD_SNP_WR    = 4'd5;
  localparam logic [3:0] CMD_SNP_RFO   = 4'd6;
  localparam logic [3:0] CMD_MNT_CLR   = 4'd8;
  localparam logic [3:0] CMD_MNT_PRINT = 4'd9;

  typedef enum logic [1:0] {
    SRC_L1D = 2'd0,
    SRC_L1I = 2'd1,
    SRC_SNP = 2'd2,
    SRC_MNT = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic cmd_legal(input src_e src, input logic [3:0] cmd);
    logic ok;
    case (src)
      SRC_L1D: ok = (cmd == CMD_DREAD) || (cmd == CMD_DWRITE);
      SRC_L1I: ok = (cmd == CMD_IREAD);
      SRC_SNP: ok = (cmd == CMD_SNP_INV) || (cmd == CMD_SNP_RD) ||
                    (cmd == CMD_SNP_WR) || (cmd == CMD_SNP_RFO);
      default: ok = (cmd == CMD_MNT_CLR) || (cmd == CMD_MNT_PRINT);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/l2_req_arbiter.sv
// Four-way request arbiter: snoop > round-robin L1D/L1I > maintenance,
// with a guard that forces an L1 grant after STARVE_MAX back-to-back snoops.
module l2_req_arbiter
  import l2_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  localparam int STARVE_W = $clog2(STARVE_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                l1d_valid,
  input  logic                l1i_valid,
  input  logic                snp_valid,
  input  logic                mnt_valid,
  output logic [3:0]          grant,
  output logic                rr_ptr_q,
  output logic [STARVE_W-1:0] starve_q
);

  logic                l1_any;
  logic                l1_pick_i;
  logic                starved;
  logic                rr_ptr_d;
  logic [STARVE_W-1:0] starve_d;

  always_comb begin
    l1_any    = l1d_valid | l1i_valid;
    // rr_ptr_q = 1 means L1I has the turn when both L1 ports ask
    l1_pick_i = l1i_valid & (~l1d_valid | rr_ptr_q);
    starved   = l1_any && (starve_q >= STARVE_W'(STARVE_MAX));
    grant     = '0;
    if (en) begin
      if (snp_valid && !starved)  grant[SRC_SNP] = 1'b1;
      else if (l1_any)            grant[l1_pick_i ? SRC_L1I : SRC_L1D] = 1'b1;
      else if (mnt_valid)         grant[SRC_MNT] = 1'b1;
    end
    rr_ptr_d = rr_ptr_q ^ (grant[SRC_L1D] | grant[SRC_L1I]);
    if (!l1_any)               starve_d = '0;
    else if (grant[SRC_SNP])   starve_d = starve_q + STARVE_W'(1);
    else if (|grant)           starve_d = '0;
    else                       starve_d = starve_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
      starve_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/l2_access_controller.sv
// L2 front-end sequencer: arbitrates four request ports, issues one L2
// transaction at a time and keeps saturating read/write/hit statistics.
//   state    | meaning
//   ST_IDLE  | arbitrate, accept one request per cycle
//   ST_ISSUE | l2_req_valid high, held stable until l2_req_ready
//   ST_WAIT  | waiting for l2_done, counters update on it
module l2_access_controller
  import l2_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1d_valid,
  output logic              l1d_ready,
  input  logic [3:0]        l1d_cmd,
  input  logic [ADDR_W-1:0] l1d_addr,
  input  logic              l1i_valid,
  output logic              l1i_ready,
  input  logic [ADDR_W-1:0] l1i_addr,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [3:0]        snp_cmd,
  input  logic [ADDR_W-1:0] snp_addr,
  input  logic              mnt_valid,
  output logic              mnt_ready,
  input  logic [3:0]        mnt_cmd,
  output logic              l2_req_valid,
  input  logic              l2_req_ready,
  output logic [3:0]        l2_req_cmd,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [1:0]        l2_req_src,
  input  logic              l2_done,
  input  logic              l2_done_hit,
  output logic              busy,
  output logic              cmd_err,
  output logic [CNT_W-1:0]  read_cnt,
  output logic [CNT_W-1:0]  write_cnt,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e              state_q, state_d;
  logic                req_valid_q, req_valid_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  src_e                src_q, src_d;
  logic                busy_q, busy_d;
  logic                cmd_err_q, cmd_err_d;
  logic [CNT_W-1:0]    read_q, read_d, write_q, write_d, hit_q, hit_d;

  logic [3:0]          grant;
  logic                rr_ptr;
  logic [STARVE_W-1:0] starve;
  logic                arb_state_unused;
  src_e                acc_src;
  logic [3:0]          acc_cmd;
  logic [ADDR_W-1:0]   acc_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  l2_req_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (rst_n && (state_q == ST_IDLE)),
    .l1d_valid (l1d_valid),
    .l1i_valid (l1i_valid),
    .snp_valid (snp_valid),
    .mnt_valid (mnt_valid),
    .grant     (grant),
    .rr_ptr_q  (rr_ptr),
    .starve_q  (starve)
  );

  // arbiter state is kept visible for debug probing only
  assign arb_state_unused = ^{rr_ptr, starve};

  assign l1d_ready    = grant[SRC_L1D];
  assign l1i_ready    = grant[SRC_L1I];
  assign snp_ready    = grant[SRC_SNP];
  assign mnt_ready    = grant[SRC_MNT];
  assign l2_req_valid = req_valid_q;
  assign l2_req_cmd   = cmd_q;
  assign l2_req_addr  = addr_q;
  assign l2_req_src   = src_q;
  assign busy         = busy_q;
  assign cmd_err      = cmd_err_q;
  assign read_cnt     = read_q;
  assign write_cnt    = write_q;
  assign hit_cnt      = hit_q;

  always_comb begin
    acc_src  = SRC_MNT;
    acc_cmd  = mnt_cmd;
    acc_addr = '0;
    if (grant[SRC_L1D]) begin
      acc_src = SRC_L1D; acc_cmd = l1d_cmd; acc_addr = l1d_addr;
    end else if (grant[SRC_L1I]) begin
      acc_src = SRC_L1I; acc_cmd = CMD_IREAD; acc_addr = l1i_addr;
    end else if (grant[SRC_SNP]) begin
      acc_src = SRC_SNP; acc_cmd = snp_cmd; acc_addr = snp_addr;
    end

    state_d     = state_q;
    req_valid_d = req_valid_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    src_d       = src_q;
    cmd_err_d   = 1'b0;
    read_d      = read_q;
    write_d     = write_q;
    hit_d       = hit_q;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          cmd_d  = acc_cmd;
          addr_d = acc_addr;
          src_d  = acc_src;
          if (cmd_legal(acc_src, acc_cmd)) begin
            state_d     = ST_ISSUE;
            req_valid_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (l2_req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (l2_done) begin
          state_d = ST_IDLE;
          if (cmd_q == CMD_MNT_CLR) begin
            read_d  = '0;
            write_d = '0;
            hit_d   = '0;
          end else if (cmd_q <= CMD_IREAD) begin
            if (cmd_q == CMD_DWRITE) write_d = sat_inc(write_q);
            else                     read_d  = sat_inc(read_q);
            if (l2_done_hit)         hit_d   = sat_inc(hit_q);
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      src_q       <= SRC_L1D;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      read_q      <= '0;
      write_q     <= '0;
      hit_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      src_q       <= src_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
      read_q      <= read_d;
      write_q     <= write_d;
      hit_q       <= hit_d;
    end
  end

endmodule

// File: doc/l2_access_controller.md
# l2_access_controller

Front-end sequencer for the L2 cache model: accepts requests from the L1 data port, the L1 instruction port, the snoop port and a maintenance port, and arbitrates among them. Issues one L2 transaction at a time over a valid/ready request channel and a done/hit response. Maintains the read/write/hit statistics the cache test flow reports. Sits between the L1/trace drivers and the L2 lookup/MESI logic.

## Interface
- ADDR_W, 32, request address width
- CNT_W, 32, width of each statistics counter
- STARVE_MAX, 4, consecutive snoop grants allowed while an L1 request waits
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- l1d_valid / l1d_ready  in / out  1  L1 data handshake
- l1d_cmd  in  4  0 = data read, 1 = data write
- l1d_addr  in  ADDR_W  L1 data address
- l1i_valid / l1i_ready  in / out  1  L1 instruction handshake; command is implicitly 2 (instruction read)
- l1i_addr  in  ADDR_W  L1 instruction address
- snp_valid / snp_ready  in / out  1  snoop handshake
- snp_cmd  in  4  3 = invalidate, 4 = read, 5 = write, 6 = RFO
- snp_addr  in  ADDR_W  snoop address
- mnt_valid / mnt_ready  in / out  1  maintenance handshake
- mnt_cmd  in  4  8 = clear, 9 = print
- l2_req_valid / l2_req_ready  out / in  1  request channel to the L2
- l2_req_cmd  out  4  command code of the issued request
- l2_req_addr  out  ADDR_W  address of the issued request
- l2_req_src  out  2  source: 0 = L1D, 1 = L1I, 2 = snoop, 3 = maintenance
- l2_done  in  1  one-cycle completion pulse from the L2
- l2_done_hit  in  1  hit flag; qualified by l2_done
- busy  out  1  high whenever the state is not IDLE
- cmd_err  out  1  one-cycle pulse when an illegal command is dropped
- read_cnt, write_cnt, hit_cnt  out  CNT_W each  statistics counters

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: hold l2_req_* stable until l2_req_ready.
  - WAIT: hold until l2_done, then return to IDLE.
- Priority in IDLE:
  - Snoop first.
  - Then L1D and L1I, round-robin. The pointer toggles to the other L1 port after each L1 grant. Reset pointer = L1D.
  - Maintenance last.
- Starvation guard: a counter tracks consecutive snoop grants made while any L1 valid was high. When it reaches STARVE_MAX, the next grant goes to the L1 winner. The counter clears on any non-snoop grant and whenever no L1 valid is high.
- Exactly one *_ready is high per cycle, and only in IDLE, for the winner. A request is accepted when its valid and ready are both high; the command, address and source are latched.
- Illegal command (l1d_cmd > 1; snp_cmd outside 3..6; mnt_cmd not 8/9):
  - The request is accepted and dropped.
  - cmd_err pulses in the next cycle.
  - The state stays in IDLE.
- Counter updates on l2_done:
  - cmd 0 or 2: read_cnt +1.
  - cmd 1: write_cnt +1.
  - cmd 0..2 with l2_done_hit: hit_cnt +1.
  - Snoop and print commands: no counter change.
  - cmd 8 (clear): all three counters go to 0.
  - All counters saturate at all-ones.
- Reset values: every *_ready, l2_req_valid, busy and cmd_err are 0. l2_req_cmd, l2_req_addr, l2_req_src and all counters are 0. State is IDLE.

## Timing
- Accept in cycle t. State is ISSUE and l2_req_valid = 1 at t+1 (registered outputs).
- l2_req_ready high in ISSUE: WAIT starts the next cycle. l2_req_valid drops together with the ISSUE exit.
- l2_done in WAIT at cycle d:
  - Counters reflect the update at d+1.
  - IDLE at d+1.
  - The next acceptance is possible at d+1.
- Best-case throughput: one transaction per 3 cycles.
- l2_done outside WAIT is ignored.
- Simultaneous valids: resolved in a single cycle; losers hold valid and are not dropped.
- rst_n low in ISSUE or WAIT: the transaction is abandoned, outputs return to reset values at the next edge, and a late l2_done is ignored.

## Structure
- Package l2_ctrl_pkg holds:
  - Command code constants 0..9, matching the trace encoding.
  - Source encoding.
  - State enum.
- Sub-module l2_req_arbiter: combinational priority, round-robin pointer and starvation counter. Inputs: four valids and an enable (IDLE). Outputs: a one-hot grant and the pointer/counter registers.

## Test plan
- L1D read 0x0000_1000 with l2_done_hit = 1 -> l2_req_cmd = 0, src = 0. After done: read_cnt = 1, hit_cnt = 1.
- L1D and L1I valid together for 4 transactions -> grant order D, I, D, I.
- Snoop valid continuously, L1D valid, STARVE_MAX = 4 -> four snoop grants, then one L1D grant, then snoop resumes.
- L1D write miss with l2_req_ready low for 5 cycles -> l2_req_* stable for all 5 cycles. After done: write_cnt = 1, hit_cnt = 0.
- Three reads, then mnt_cmd = 8 -> after its done, all counters = 0. mnt_cmd = 9 -> counters unchanged.
- l1d_cmd = 7 -> one cmd_err pulse and no l2_req_valid. rst_n low during WAIT -> busy = 0 next cycle; a following l2_done has no effect on the counters.
